stall_scheduler: RTL and testbench
==================================

# stall_scheduler

Pipeline stall/flush scheduler for the 5-stage MIPS core. It decides each cycle whether the front end advances, holds or flushes, and whether the back-end pipeline registers are frozen. Inputs are load-use hazards, multi-cycle multiply/divide occupancy, taken branches and the data-memory ready handshake. It sits beside the ID stage and drives the PC, IF/ID and ID/EX control-mux enables; it also owns the HI/LO multiply/divide busy timer.

## Interface
- MD_LATENCY, 32, cycles a mult/div occupies the HI/LO unit (≥2)
- MEM_TIMEOUT, 255, data-memory wait cycles before memError sets (≥1)
- CNT_W, 16, width of performance counters
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- Rs, Rt  in  5 each  ID-stage source registers
- IdExRt  in  5  EX-stage destination (Rt)
- IdExMemRead  in  1  EX-stage instruction is a load
- IdUsesMd  in  1  ID-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- mdStart  in  1  EX-stage mult/div issues this cycle
- branchTaken  in  1  ID-stage branch/jump resolved taken
- memReq, memReady  in  1 each  MEM-stage access request / memory ready
- PCWrite, IfIdWrite  out  1 each  PC and IF/ID write enables
- controlSel  out  1  1 = pass ID control to ID/EX, 0 = inject bubble
- IfIdFlush  out  1  zero IF/ID next edge
- BackWrite  out  1  enable for ID/EX, EX/MEM, MEM/WB registers
- mdBusy, mdDone  out  1 each  HI/LO unit busy / last busy cycle
- memError  out  1  sticky memory-timeout flag
- stallCycles, flushCount  out  CNT_W each  saturating performance counters

## Operation
- Freeze: memReq && !memReady → PCWrite=IfIdWrite=BackWrite=0, controlSel=1, IfIdFlush=0.
- Load-use: IdExMemRead && ((Rs==IdExRt && Rs!=0) || (Rt==IdExRt && Rt!=0)).
- MD hazard: IdUsesMd && (mdBusy || mdStart).
- Front stall (load-use or MD hazard, no freeze) → PCWrite=IfIdWrite=0, controlSel=0, BackWrite=1, IfIdFlush=0.
- Branch: branchTaken with no freeze and no front stall → IfIdFlush=1. All enables are 1. If a stall or freeze is present, branchTaken is ignored that cycle.
- Priority: freeze > front stall > branch > run. Run: all enables 1, controlSel=1, IfIdFlush=0.
- Stall/flush outputs are combinational from the inputs and registered state. While rst=1: PCWrite=IfIdWrite=BackWrite=0, controlSel=1, IfIdFlush=0.
- MD timer: mdStart (with BackWrite=1) loads the counter. mdBusy is high for exactly MD_LATENCY cycles starting the next cycle. mdDone is high only in the final busy cycle. The timer keeps running during freeze. mdStart while mdBusy is ignored, since the MD hazard prevents it by construction.
- Memory FSM has two states, RUN and MEM_WAIT.
  - RUN→MEM_WAIT on memReq && !memReady, with the wait counter cleared to 1.
  - MEM_WAIT increments the wait counter (saturating) each cycle and returns to RUN on memReady.
  - When the counter equals MEM_TIMEOUT, memError sets. memError stays set until rst.
  - Freeze follows the inputs only; the timeout does not release it.
- stallCycles increments every cycle PCWrite=0 outside reset. flushCount increments every cycle IfIdFlush=1. Both saturate at all-ones.

## Timing
- Reset values: mdBusy=0, mdDone=0, memError=0, stallCycles=0, flushCount=0, FSM=RUN, MD counter=0.
- Hazard and freeze responses take zero cycles (same-cycle combinational).
- A load-use stall lasts exactly 1 cycle unless freeze extends it.
- mdStart at edge N → mdBusy from cycle N+1 through N+MD_LATENCY; mdDone in cycle N+MD_LATENCY.
- memError is visible the cycle after the MEM_TIMEOUT-th wait cycle.
- rst asserted mid-wait or mid-multiply returns to reset values immediately; no pending state survives.

## Structure
- Package pipeline_pkg holds the register-index width (5), a stall-cause enum (CAUSE_NONE, CAUSE_FREEZE, CAUSE_LOADUSE, CAUSE_MD, CAUSE_BRANCH) used internally for priority decode, and default latency constants.
- One sub-module, md_busy_timer: mdStart in; mdBusy/mdDone out; parameter MD_LATENCY.

## Test plan
- Load-use: IdExMemRead=1, IdExRt=5, Rs=5 → one cycle with PCWrite=0, controlSel=0; stallCycles=1. Same with Rs=Rt=IdExRt=0 → no stall.
- MD: mdStart at cycle 0, MD_LATENCY=4, IdUsesMd=1 held → mdBusy in cycles 1–4, mdDone in cycle 4, front stall in cycles 0–4, release in cycle 5.
- Freeze over stall: memReq=1, memReady=0 for 3 cycles during a load-use hazard → BackWrite=0, controlSel=1 for 3 cycles, then a 1-cycle bubble.
- Branch: branchTaken=1 alone → IfIdFlush=1, flushCount=1. branchTaken with load-use → IfIdFlush=0.
- Timeout: MEM_TIMEOUT=4, memReady low for 6 cycles → memError set after the 4th wait cycle and still set after memReady rises.
- Reset: rst pulsed mid-multiply and mid-wait → mdBusy=0, memError=0, counters 0 asynchronously.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIPS pipeline hazard control:
// register-index width, stall causes, control-enable bundle and priority decode.
package pipeline_pkg;

   localparam int REG_W               = 5;
   localparam int DEFAULT_MD_LATENCY  = 32;
   localparam int DEFAULT_MEM_TIMEOUT = 255;
   localparam int DEFAULT_CNT_W       = 16;

   typedef logic [REG_W-1:0] reg_idx_t;

   typedef enum logic [2:0] {
      CAUSE_NONE,
      CAUSE_FREEZE,
      CAUSE_LOADUSE,
      CAUSE_MD,
      CAUSE_BRANCH
   } stall_cause_e;

   typedef enum logic {
      ST_RUN,
      ST_MEM_WAIT
   } mem_state_e;

   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic control_sel;
      logic if_id_flush;
      logic back_write;
   } pipe_ctrl_t;

   localparam pipe_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, control_sel: 1'b1,
                                          if_id_flush: 1'b0, back_write: 1'b1};
   localparam pipe_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, control_sel: 1'b1,
                                          if_id_flush: 1'b0, back_write: 1'b0};
   localparam pipe_ctrl_t CTRL_BUBBLE = '{pc_write: 1'b0, if_id_write: 1'b0, control_sel: 1'b0,
                                          if_id_flush: 1'b0, back_write: 1'b1};
   localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, control_sel: 1'b1,
                                          if_id_flush: 1'b1, back_write: 1'b1};
   // Reset holds the whole pipe exactly like a memory freeze.
   localparam pipe_ctrl_t CTRL_RESET  = CTRL_FREEZE;

   // $zero never carries a dependency, so a match on register 0 is not a hazard.
   function automatic logic src_matches(input reg_idx_t src, input reg_idx_t dst);
      return (src == dst) && (src != '0);
   endfunction

   function automatic stall_cause_e decode_cause(input logic freeze,
                                                 input logic load_use,
                                                 input logic md_hazard,
                                                 input logic branch);
      if (freeze)    return CAUSE_FREEZE;
      if (load_use)  return CAUSE_LOADUSE;
      if (md_hazard) return CAUSE_MD;
      if (branch)    return CAUSE_BRANCH;
      return CAUSE_NONE;
   endfunction

   function automatic pipe_ctrl_t ctrl_for_cause(input stall_cause_e cause);
      case (cause)
         CAUSE_FREEZE:           return CTRL_FREEZE;
         CAUSE_LOADUSE, CAUSE_MD: return CTRL_BUBBLE;
         CAUSE_BRANCH:           return CTRL_FLUSH;
         default:                return CTRL_RUN;
      endcase
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// HI/LO multiply/divide occupancy timer: an accepted start makes md_busy high for
// exactly MD_LATENCY cycles, with md_done marking the last of them.
module md_busy_timer
   import pipeline_pkg::*;
#(
   parameter int MD_LATENCY = DEFAULT_MD_LATENCY
) (
   input  logic clk,
   input  logic rst,
   input  logic md_start,
   output logic md_busy,
   output logic md_done
);

   localparam int              CW       = $clog2(MD_LATENCY + 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]   CNT_LOAD = CW'(MD_LATENCY);

   logic [CW-1:0] cnt_q, cnt_d;

   // A start arriving while the unit is occupied is dropped; the ID-stage MD
   // hazard keeps a second mult/div from issuing in that window anyway.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end else if (md_start) begin
         cnt_d = CNT_LOAD;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign md_busy = (cnt_q != '0);
   assign md_done = (cnt_q == CNT_ONE);

endmodule

// File: rtl/stall_scheduler.sv
// Stall/flush scheduler beside the ID stage: decodes freeze, load-use, MD and
// branch conditions into PC / IF/ID / ID/EX enables and tracks memory timeouts.
module stall_scheduler
   import pipeline_pkg::*;
#(
   parameter int MD_LATENCY  = DEFAULT_MD_LATENCY,
   parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] Rs,
   input  logic [REG_W-1:0] Rt,
   input  logic [REG_W-1:0] IdExRt,
   input  logic             IdExMemRead,
   input  logic             IdUsesMd,
   input  logic             mdStart,
   input  logic             branchTaken,
   input  logic             memReq,
   input  logic             memReady,
   output logic             PCWrite,
   output logic             IfIdWrite,
   output logic             controlSel,
   output logic             IfIdFlush,
   output logic             BackWrite,
   output logic             mdBusy,
   output logic             mdDone,
   output logic             memError,
   output logic [CNT_W-1:0] stallCycles,
   output logic [CNT_W-1:0] flushCount
);

   localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   logic         freeze;
   logic         load_use;
   logic         md_hazard;
   logic         md_start_ok;
   logic         md_busy;
   logic         md_done;
   stall_cause_e cause;
   pipe_ctrl_t   ctrl;

   mem_state_e        state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_error_q, mem_error_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   // Hazard responses are same-cycle: everything here is combinational from
   // the current inputs and already-registered state.
   always_comb begin
      freeze    = memReq && !memReady;
      load_use  = IdExMemRead && (src_matches(Rs, IdExRt) || src_matches(Rt, IdExRt));
      md_hazard = IdUsesMd && (md_busy || mdStart);
      cause     = decode_cause(freeze, load_use, md_hazard, branchTaken);
      ctrl      = rst ? CTRL_RESET : ctrl_for_cause(cause);
   end

   // A mult/div only really issues when the back end is advancing.
   assign md_start_ok = mdStart && ctrl.back_write;

   md_busy_timer #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_timer (
      .clk      (clk),
      .rst      (rst),
      .md_start (md_start_ok),
      .md_busy  (md_busy),
      .md_done  (md_done)
   );

   // NOTE: every next-state variable takes its hold value first, so no path
   // through this block can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      mem_error_d = mem_error_q;
      case (state_q)
         ST_RUN: begin
            if (freeze) begin
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_ONE;
            end
         end
         ST_MEM_WAIT: begin
            if (memReady) begin
               state_d = ST_RUN;
            end else if (wait_q != WAIT_LIMIT) begin
               wait_d = wait_q + WAIT_ONE;
            end
         end
      endcase
      // Sticky: only reset clears a timeout, and it never releases the freeze.
      if ((state_d == ST_MEM_WAIT) && (wait_d == WAIT_LIMIT)) begin
         mem_error_d = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      if (ctrl.if_id_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
   end

   // NOTE: non-blocking assignments here so every flop samples pre-edge values
   // regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_q      <= '0;
         mem_error_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         mem_error_q <= mem_error_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign PCWrite     = ctrl.pc_write;
   assign IfIdWrite   = ctrl.if_id_write;
   assign controlSel  = ctrl.control_sel;
   assign IfIdFlush   = ctrl.if_id_flush;
   assign BackWrite   = ctrl.back_write;
   assign mdBusy      = md_busy;
   assign mdDone      = md_done;
   assign memError    = mem_error_q;
   assign stallCycles = stall_cnt_q;
   assign flushCount  = flush_cnt_q;

endmodule

// File: tb/tb_stall_scheduler.sv
// Directed bench for stall_scheduler: a per-cycle reference model compared on
// every falling edge, plus literal expectations for each hazard scenario.
module tb_stall_scheduler;

   localparam int LAT     = 4;
   localparam int TMO     = 4;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    Rs, Rt, IdExRt;
   logic          IdExMemRead, IdUsesMd, mdStart, branchTaken, memReq, memReady;
   logic          PCWrite, IfIdWrite, controlSel, IfIdFlush, BackWrite;
   logic          mdBusy, mdDone, memError;
   logic [CW-1:0] stallCycles, flushCount;

   stall_scheduler #(
      .MD_LATENCY  (LAT),
      .MEM_TIMEOUT (TMO),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .Rs          (Rs),
      .Rt          (Rt),
      .IdExRt      (IdExRt),
      .IdExMemRead (IdExMemRead),
      .IdUsesMd    (IdUsesMd),
      .mdStart     (mdStart),
      .branchTaken (branchTaken),
      .memReq      (memReq),
      .memReady    (memReady),
      .PCWrite     (PCWrite),
      .IfIdWrite   (IfIdWrite),
      .controlSel  (controlSel),
      .IfIdFlush   (IfIdFlush),
      .BackWrite   (BackWrite),
      .mdBusy      (mdBusy),
      .mdDone      (mdDone),
      .memError    (memError),
      .stallCycles (stallCycles),
      .flushCount  (flushCount)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
      end
   endtask

   // Reference model state: remaining MD busy cycles, memory wait tracking,
   // and plain integer counters.
   int m_md_rem  = 0;
   bit m_in_wait = 1'b0;
   int m_waited  = 0;
   bit m_err     = 1'b0;
   int m_stall   = 0;
   int m_flush   = 0;
   bit e_pc = 1'b0, e_ifid = 1'b0, e_back = 1'b0, e_csel = 1'b1, e_flush = 1'b0;

   always @(negedge clk) begin : compare
      bit fr, lu, mdh;
      fr  = memReq && !memReady;
      lu  = IdExMemRead && (((Rs == IdExRt) && (Rs != 0)) || ((Rt == IdExRt) && (Rt != 0)));
      mdh = IdUsesMd && ((m_md_rem > 0) || mdStart);
      if (rst || fr)        {e_pc, e_ifid, e_back, e_csel, e_flush} = 5'b00010;
      else if (lu || mdh)   {e_pc, e_ifid, e_back, e_csel, e_flush} = 5'b00100;
      else if (branchTaken) {e_pc, e_ifid, e_back, e_csel, e_flush} = 5'b11111;
      else                  {e_pc, e_ifid, e_back, e_csel, e_flush} = 5'b11110;
      check("PCWrite",     PCWrite,     e_pc);
      check("IfIdWrite",   IfIdWrite,   e_ifid);
      check("BackWrite",   BackWrite,   e_back);
      check("controlSel",  controlSel,  e_csel);
      check("IfIdFlush",   IfIdFlush,   e_flush);
      check("mdBusy",      mdBusy,      m_md_rem > 0);
      check("mdDone",      mdDone,      m_md_rem == 1);
      check("memError",    memError,    m_err);
      check("stallCycles", stallCycles, m_stall);
      check("flushCount",  flushCount,  m_flush);
   end

   always @(posedge clk or posedge rst) begin : model
      if (rst) begin
         m_md_rem  = 0;
         m_in_wait = 1'b0;
         m_waited  = 0;
         m_err     = 1'b0;
         m_stall   = 0;
         m_flush   = 0;
      end else begin
         if (!e_pc && (m_stall < CNT_MAX)) m_stall++;
         if (e_flush && (m_flush < CNT_MAX)) m_flush++;
         if (m_md_rem > 0) m_md_rem--;
         else if (mdStart && e_back) m_md_rem = LAT;
         if (!m_in_wait) begin
            if (memReq && !memReady) begin
               m_in_wait = 1'b1;
               m_waited  = 1;
            end
         end else if (memReady) begin
            m_in_wait = 1'b0;
         end else begin
            m_waited++;
         end
         if (m_in_wait && (m_waited >= TMO)) m_err = 1'b1;
      end
   end

   task automatic clear_in();
      Rs = '0; Rt = '0; IdExRt = '0;
      IdExMemRead = 1'b0; IdUsesMd = 1'b0; mdStart = 1'b0;
      branchTaken = 1'b0; memReq = 1'b0; memReady = 1'b0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic do_reset();
      cyc();
      clear_in();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      clear_in();
      rst = 1'b1;
      cyc();
      cyc();
      settle();
      check("rst_pcwrite", PCWrite, 0);
      check("rst_csel",    controlSel, 1);
      check("rst_back",    BackWrite, 0);
      check("rst_stall",   stallCycles, 0);
      check("rst_mdbusy",  mdBusy, 0);
      check("rst_memerr",  memError, 0);
      rst = 1'b0;

      // Load-use on Rs, then through $zero, then on Rt, then without a load.
      cyc(); IdExMemRead = 1'b1; IdExRt = 5'd5; Rs = 5'd5; settle();
      check("lu_pcwrite", PCWrite, 0);
      check("lu_csel",    controlSel, 0);
      check("lu_back",    BackWrite, 1);
      cyc(); clear_in(); settle();
      check("lu_stallcnt", stallCycles, 1);
      check("lu_release",  PCWrite, 1);
      cyc(); IdExMemRead = 1'b1; settle();
      check("lu_zero_pcwrite", PCWrite, 1);
      cyc(); clear_in(); settle();
      check("lu_zero_stallcnt", stallCycles, 1);
      cyc(); IdExMemRead = 1'b1; IdExRt = 5'd9; Rt = 5'd9; Rs = 5'd3; settle();
      check("lu_rt_pcwrite", PCWrite, 0);
      cyc(); IdExMemRead = 1'b0; settle();
      check("lu_noload_pcwrite", PCWrite, 1);

      // Multiply occupancy with a dependent instruction waiting in ID.
      do_reset();
      cyc(); mdStart = 1'b1; IdUsesMd = 1'b1; settle();
      check("md_c0_pcwrite", PCWrite, 0);
      check("md_c0_busy",    mdBusy, 0);
      for (int k = 1; k <= LAT; k++) begin
         cyc(); mdStart = 1'b0; settle();
         check("md_busy",    mdBusy, 1);
         check("md_done",    mdDone, k == LAT);
         check("md_pcwrite", PCWrite, 0);
      end
      cyc(); settle();
      check("md_release_pcwrite", PCWrite, 1);
      check("md_release_busy",    mdBusy, 0);
      check("md_stallcnt",        stallCycles, LAT + 1);

      // Freeze dominates a load-use stall, which then costs one bubble.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         cyc(); IdExMemRead = 1'b1; IdExRt = 5'd7; Rs = 5'd7; memReq = 1'b1; memReady = 1'b0;
         settle();
         check("frz_back", BackWrite, 0);
         check("frz_csel", controlSel, 1);
      end
      cyc(); memReady = 1'b1; settle();
      check("frz_bubble_back", BackWrite, 1);
      check("frz_bubble_csel", controlSel, 0);
      cyc(); clear_in(); settle();
      check("frz_stallcnt", stallCycles, 4);
      check("frz_noerr",    memError, 0);

      // Branch flush, and branches suppressed by stall or freeze.
      do_reset();
      cyc(); branchTaken = 1'b1; settle();
      check("br_flush",   IfIdFlush, 1);
      check("br_pcwrite", PCWrite, 1);
      cyc(); clear_in(); settle();
      check("br_flushcnt", flushCount, 1);
      cyc(); branchTaken = 1'b1; IdExMemRead = 1'b1; IdExRt = 5'd3; Rs = 5'd3; settle();
      check("br_lu_flush", IfIdFlush, 0);
      cyc(); clear_in(); branchTaken = 1'b1; memReq = 1'b1; settle();
      check("br_frz_flush", IfIdFlush, 0);
      cyc(); clear_in(); memReady = 1'b1; settle();
      check("br_flushcnt_hold", flushCount, 1);

      // Memory timeout: error appears after the fourth wait cycle and sticks.
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         cyc(); memReq = 1'b1; memReady = 1'b0; settle();
         check("tmo_err", memError, k >= TMO + 1);
      end
      cyc(); memReady = 1'b1; settle();
      check("tmo_err_ready", memError, 1);
      cyc(); clear_in(); settle();
      check("tmo_err_sticky", memError, 1);
      check("tmo_stallcnt",   stallCycles, 6);

      // Counter saturation.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         cyc(); IdExMemRead = 1'b1; IdExRt = 5'd2; Rt = 5'd2;
      end
      cyc(); clear_in(); settle();
      check("sat_stallcnt", stallCycles, CNT_MAX);

      // Asynchronous reset mid-multiply and mid-wait.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cyc(); memReq = 1'b1; memReady = 1'b0;
      end
      cyc(); memReady = 1'b1; mdStart = 1'b1; branchTaken = 1'b1; settle();
      cyc(); clear_in(); memReq = 1'b1; settle();
      check("ar_pre_busy", mdBusy, 1);
      check("ar_pre_err",  memError, 1);
      rst = 1'b1;
      #1;
      check("ar_busy",     mdBusy, 0);
      check("ar_err",      memError, 0);
      check("ar_stallcnt", stallCycles, 0);
      check("ar_flushcnt", flushCount, 0);
      check("ar_pcwrite",  PCWrite, 0);
      check("ar_csel",     controlSel, 1);
      cyc(); rst = 1'b0; clear_in();
      cyc(); settle();
      check("ar_post_busy", mdBusy, 0);
      check("ar_post_err",  memError, 0);
      cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
